lcd_text_ctrl: RTL and testbench

Parametrised HD44780-class character LCD controller (8-bit bus) for the LCD display path. After power-on delay, it runs a fixed init command sequence. On request, it writes an NUM_CHARS-byte text buffer to DDRAM with automatic line wrapping. Every LCD access is a timed bus cycle, and completion is detected by busy-flag polling with a timeout. A host loads the buffer through a simple write port and triggers refreshes.

---
 rtl/lcd_text_ctrl_if.sv | 31 +++
 rtl/lcd_text_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_lcd_text_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_text_ctrl_if.sv
// Host and LCD-bus signal bundle for the character LCD controller.
// The slave modport is the controller's view; the master modport is the
// host/LCD-side view (buffer writes, refresh requests, bus read-back).
interface lcd_text_ctrl_if;
  logic       buf_we;
  logic [4:0] buf_addr;
  logic [7:0] buf_wdata;
  logic       refresh;
  logic       ready;
  logic       done;
  logic       err;
  logic       rs_lcd;
  logic       rw_lcd;
  logic       en_lcd;
  logic       on_lcd;
  logic [7:0] data_lcd_o;
  logic [7:0] data_lcd_i;
  logic       data_lcd_oe;

  modport slave (
    input  buf_we, buf_addr, buf_wdata, refresh, data_lcd_i,
    output ready, done, err, rs_lcd, rw_lcd, en_lcd, on_lcd,
           data_lcd_o, data_lcd_oe
  );

  modport master (
    output buf_we, buf_addr, buf_wdata, refresh, data_lcd_i,
    input  ready, done, err, rs_lcd, rw_lcd, en_lcd, on_lcd,
           data_lcd_o, data_lcd_oe
  );
endinterface

// File: rtl/lcd_text_ctrl.sv
// HD44780-class character LCD controller, 8-bit bus.
// Power-on wait, fixed init command list, then on request rewrites the text
// buffer to DDRAM (line 2 starts at char 16). Each byte is a timed write
// followed by busy-flag polls; too many busy polls abort with a sticky err.
module lcd_text_ctrl #(
  parameter int NUM_CHARS = 16,
  parameter int POR_CYC   = 750000,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12,
  parameter int HOLD_CYC  = 2,
  parameter int BUSY_MAX  = 4095
) (
  input logic           clk,
  input logic           rst,
  lcd_text_ctrl_if.slave lcd
);

  localparam int PH_MAX    = (SETUP_CYC > EN_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
  localparam int PW        = $clog2(POR_CYC + 1);
  localparam int CW        = $clog2(PH_MAX + 1);
  localparam int BW        = $clog2(BUSY_MAX + 1);
  localparam int LINE1     = (NUM_CHARS > 16) ? 16 : NUM_CHARS;
  localparam int LAST_STEP = NUM_CHARS + ((NUM_CHARS > 16) ? 1 : 0);

  localparam logic [PW-1:0] POR_LAST   = PW'(POR_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [BW-1:0] BUSY_LAST  = BW'(BUSY_MAX - 1);
  localparam logic [5:0]    LINE1_S    = 6'(LINE1);
  localparam logic [5:0]    LAST_S     = 6'(LAST_STEP);
  localparam logic [5:0]    NUM_S      = 6'(NUM_CHARS);

  typedef enum logic [1:0] {
    T_POR, T_INIT, T_IDLE, T_REFRESH
  } top_e;

  typedef enum logic [2:0] {
    PH_IDLE, PH_LOAD, PH_SETUP, PH_EN_HI, PH_HOLD, PH_P_SETUP, PH_P_EN, PH_P_HOLD
  } phase_e;

  top_e          top_q;
  phase_e        phase_q;
  logic [PW-1:0] por_cnt_q;
  logic [CW-1:0] cnt_q;
  logic [BW-1:0] poll_q;
  logic [5:0]    seq_q;
  logic          bf_q;
  logic          rs_q;
  logic          rw_q;
  logic          en_q;
  logic          oe_q;
  logic [7:0]    dout_q;
  logic          ready_q;
  logic          done_q;
  logic          err_q;

  logic [7:0]    mem_q [0:31];

  logic          rs_d;
  logic [7:0]    byte_d;
  logic [4:0]    char_idx;
  logic [5:0]    last_seq;

  logic          unused_bus_bits;
  assign unused_bus_bits = ^lcd.data_lcd_i[6:0];

  // Text buffer: host writes beyond the configured length are dropped
  always_ff @(posedge clk) begin
    if (lcd.buf_we && ({1'b0, lcd.buf_addr} < NUM_S)) begin
      mem_q[lcd.buf_addr] <= lcd.buf_wdata;
    end
  end

  // Select the register-select and byte for the current sequence step
  always_comb begin
    rs_d     = 1'b0;
    byte_d   = 8'h00;
    char_idx = 5'd0;
    last_seq = LAST_S;
    if (top_q == T_INIT) begin
      last_seq = 6'd3;
      case (seq_q[1:0])
        2'd0:    byte_d = 8'h38;
        2'd1:    byte_d = 8'h0C;
        2'd2:    byte_d = 8'h06;
        default: byte_d = 8'h01;
      endcase
    end else begin
      if (seq_q == 6'd0) begin
        byte_d = 8'h80;
      end else if (seq_q <= LINE1_S) begin
        rs_d     = 1'b1;
        char_idx = 5'(seq_q - 6'd1);
        byte_d   = mem_q[char_idx];
      end else if (seq_q == LINE1_S + 6'd1) begin
        byte_d = 8'hC0;
      end else begin
        rs_d     = 1'b1;
        char_idx = 5'(seq_q - 6'd2);
        byte_d   = mem_q[char_idx];
      end
    end
  end

  // Top-level sequencer and byte-cycle engine with registered bus outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q     <= T_POR;
      phase_q   <= PH_IDLE;
      por_cnt_q <= '0;
      cnt_q     <= '0;
      poll_q    <= '0;
      seq_q     <= '0;
      bf_q      <= 1'b0;
      rs_q      <= 1'b0;
      rw_q      <= 1'b1;
      en_q      <= 1'b0;
      oe_q      <= 1'b0;
      dout_q    <= 8'h00;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (top_q)
        T_POR: begin
          if (por_cnt_q == POR_LAST) begin
            top_q   <= T_INIT;
            seq_q   <= 6'd0;
            phase_q <= PH_LOAD;
          end else begin
            por_cnt_q <= por_cnt_q + PW'(1);
          end
        end

        T_IDLE: begin
          if (lcd.refresh) begin
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            top_q   <= T_REFRESH;
            seq_q   <= 6'd0;
            phase_q <= PH_LOAD;
          end
        end

        default: begin
          case (phase_q)
            // Latch the byte here so later buffer writes cannot disturb it
            PH_LOAD: begin
              dout_q  <= byte_d;
              rs_q    <= rs_d;
              rw_q    <= 1'b0;
              oe_q    <= 1'b1;
              en_q    <= 1'b0;
              cnt_q   <= '0;
              poll_q  <= '0;
              phase_q <= PH_SETUP;
            end

            PH_SETUP: begin
              if (cnt_q == SETUP_LAST) begin
                en_q    <= 1'b1;
                cnt_q   <= '0;
                phase_q <= PH_EN_HI;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end

            PH_EN_HI: begin
              if (cnt_q == EN_LAST) begin
                en_q    <= 1'b0;
                cnt_q   <= '0;
                phase_q <= PH_HOLD;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end

            // Bus release and read direction switch happen on the same edge
            PH_HOLD: begin
              if (cnt_q == HOLD_LAST) begin
                oe_q    <= 1'b0;
                rw_q    <= 1'b1;
                rs_q    <= 1'b0;
                cnt_q   <= '0;
                phase_q <= PH_P_SETUP;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end

            PH_P_SETUP: begin
              if (cnt_q == SETUP_LAST) begin
                en_q    <= 1'b1;
                cnt_q   <= '0;
                phase_q <= PH_P_EN;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end

            PH_P_EN: begin
              if (cnt_q == EN_LAST) begin
                bf_q    <= lcd.data_lcd_i[7];
                en_q    <= 1'b0;
                cnt_q   <= '0;
                phase_q <= PH_P_HOLD;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end

            PH_P_HOLD: begin
              if (cnt_q == HOLD_LAST) begin
                cnt_q <= '0;
                if (bf_q) begin
                  if (poll_q == BUSY_LAST) begin
                    err_q   <= 1'b1;
                    ready_q <= 1'b1;
                    top_q   <= T_IDLE;
                    phase_q <= PH_IDLE;
                  end else begin
                    poll_q  <= poll_q + BW'(1);
                    phase_q <= PH_P_SETUP;
                  end
                end else if (seq_q == last_seq) begin
                  ready_q <= 1'b1;
                  done_q  <= (top_q == T_REFRESH);
                  top_q   <= T_IDLE;
                  phase_q <= PH_IDLE;
                end else begin
                  seq_q   <= seq_q + 6'd1;
                  phase_q <= PH_LOAD;
                end
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end

            default: begin
              phase_q <= PH_IDLE;
            end
          endcase
        end
      endcase
    end
  end

  assign lcd.rs_lcd      = rs_q;
  assign lcd.rw_lcd      = rw_q;
  assign lcd.en_lcd      = en_q;
  assign lcd.on_lcd      = 1'b1;
  assign lcd.data_lcd_o  = dout_q;
  assign lcd.data_lcd_oe = oe_q;
  assign lcd.ready       = ready_q;
  assign lcd.done        = done_q;
  assign lcd.err         = err_q;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Bench for lcd_text_ctrl: an LCD bus model logs every write strobe and
// answers busy polls; expected byte streams come from the text rules.
module tb_lcd_text_ctrl;

  localparam int NUM  = 20;
  localparam int POR  = 20;
  localparam int SU   = 1;
  localparam int EN   = 2;
  localparam int HO   = 1;
  localparam int BMAX = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lcd_text_ctrl_if bus ();

  lcd_text_ctrl #(
    .NUM_CHARS(NUM), .POR_CYC(POR), .SETUP_CYC(SU),
    .EN_CYC(EN), .HOLD_CYC(HO), .BUSY_MAX(BMAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .lcd(bus.slave)
  );

  // LCD model state (written only by the monitor)
  logic [8:0] wlog [0:1023];
  int   wcnt = 0, polls = 0, done_cnt = 0, done_noready = 0;
  int   bad_width = 0, bad_oe = 0, overlap = 0, hi_len = 0, busy_left = 0;
  logic prev_en = 1'b0;
  // Controls set by the stimulus
  bit   stuck_bf = 1'b0;
  bit   arm_busy3 = 1'b0;

  assign bus.data_lcd_i = {(stuck_bf || (busy_left != 0)), 7'h00};

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.data_lcd_oe && bus.rw_lcd) overlap++;
      if (bus.en_lcd && !prev_en) begin
        hi_len = 1;
        if (!bus.rw_lcd) begin
          wlog[wcnt] = {bus.rs_lcd, bus.data_lcd_o};
          wcnt++;
          if (!bus.data_lcd_oe) bad_oe++;
          if (arm_busy3 && !bus.rs_lcd && bus.data_lcd_o == 8'h01) busy_left = 3;
        end else begin
          polls++;
        end
      end else if (bus.en_lcd) begin
        hi_len++;
      end
      if (!bus.en_lcd && prev_en) begin
        if (hi_len != EN) bad_width++;
        if (bus.rw_lcd && busy_left > 0) busy_left--;
      end
      if (bus.done) begin
        done_cnt++;
        if (!bus.ready) done_noready++;
      end
    end
    prev_en = bus.en_lcd;
  end

  // Reference data and bookkeeping
  logic [7:0] bufm [0:31];
  logic [8:0] exp_q [$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic build_init_exp();
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h06});
    exp_q.push_back({1'b0, 8'h01});
  endtask

  task automatic build_refresh_exp();
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < NUM && i < 16; i++) exp_q.push_back({1'b1, bufm[i]});
    if (NUM > 16) begin
      exp_q.push_back({1'b0, 8'hC0});
      for (int i = 16; i < NUM; i++) exp_q.push_back({1'b1, bufm[i]});
    end
  endtask

  task automatic check_seq(input int base, input string tag);
    chk($sformatf("%s_len", tag), wcnt - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), {23'd0, wlog[base + i]}, {23'd0, exp_q[i]});
  endtask

  task automatic buf_write(input logic [4:0] a, input logic [7:0] d);
    bus.buf_we    = 1'b1;
    bus.buf_addr  = a;
    bus.buf_wdata = d;
    @(negedge clk);
    bus.buf_we = 1'b0;
    if (a < NUM) bufm[a] = d;
  endtask

  task automatic pulse_refresh();
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
  endtask

  task automatic wait_ready(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ready) begin ok = 1'b1; break; end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(input int budget, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin ok = 1'b1; break; end
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, dbase, pbase, en_seen;
    bit found;
    rst = 1'b1;
    bus.buf_we = 1'b0; bus.buf_addr = '0; bus.buf_wdata = '0; bus.refresh = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_en",    bus.en_lcd, 0);
    chk("rst_rw",    bus.rw_lcd, 1);
    chk("rst_rs",    bus.rs_lcd, 0);
    chk("rst_oe",    bus.data_lcd_oe, 0);
    chk("rst_data",  bus.data_lcd_o, 0);
    chk("rst_on",    bus.on_lcd, 1);
    chk("rst_ready", bus.ready, 0);
    chk("rst_done",  bus.done, 0);
    chk("rst_err",   bus.err, 0);

    // Init with three busy polls after the clear-display command
    arm_busy3 = 1'b1;
    rst = 1'b0;
    en_seen = 0;
    repeat (POR) begin
      @(negedge clk);
      if (bus.en_lcd) en_seen++;
    end
    chk("por_quiet", en_seen, 0);
    wait_ready(2000, "init_ready");
    repeat (2) @(negedge clk);
    build_init_exp();
    check_seq(0, "init");
    chk("init_polls", polls, 7);
    chk("init_err", bus.err, 0);
    arm_busy3 = 1'b0;

    // Buffer "PRAN" + random text, plus writes outside the buffer
    buf_write(5'd0, 8'h50); buf_write(5'd1, 8'h52);
    buf_write(5'd2, 8'h41); buf_write(5'd3, 8'h4E);
    for (int i = 4; i < 32; i++) buf_write(5'(i), 8'($urandom_range(32, 126)));
    buf_write(5'd5, 8'h7A);

    base = wcnt; dbase = done_cnt;
    pulse_refresh();
    chk("ref1_ack_ready", bus.ready, 0);
    repeat (30) @(negedge clk);
    pulse_refresh();
    wait_done(1000, "ref1_done_seen");
    chk("ref1_done_ready", bus.ready, 1);
    repeat (50) @(negedge clk);
    build_refresh_exp();
    check_seq(base, "ref1");
    chk("ref1_done_cnt", done_cnt - dbase, 1);
    chk("ref1_err", bus.err, 0);

    // Busy flag stuck high: timeout after BMAX polls
    for (int i = 0; i < 4; i++) buf_write(5'($urandom_range(0, NUM - 1)), 8'($urandom_range(32, 126)));
    stuck_bf = 1'b1;
    base = wcnt; dbase = done_cnt; pbase = polls;
    pulse_refresh();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.err) begin found = 1'b1; break; end
    end
    chk("to_err_seen", {31'd0, found}, 1);
    repeat (20) @(negedge clk);
    chk("to_polls", polls - pbase, BMAX);
    chk("to_writes", wcnt - base, 1);
    chk("to_first", {23'd0, wlog[base]}, {23'd0, 9'h080});
    chk("to_no_done", done_cnt - dbase, 0);
    chk("to_ready", bus.ready, 1);
    chk("to_err", bus.err, 1);

    // Recovery refresh clears err
    stuck_bf = 1'b0;
    base = wcnt; dbase = done_cnt;
    pulse_refresh();
    chk("rec_err_clr", bus.err, 0);
    chk("rec_ready_lo", bus.ready, 0);
    wait_done(1000, "rec_done_seen");
    repeat (50) @(negedge clk);
    build_refresh_exp();
    check_seq(base, "rec");
    chk("rec_done_cnt", done_cnt - dbase, 1);
    chk("rec_err", bus.err, 0);

    // Asynchronous reset while en_lcd is high mid-refresh
    base = wcnt;
    pulse_refresh();
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if ((wcnt - base) >= 5 && bus.en_lcd) begin found = 1'b1; break; end
    end
    chk("mid_en_seen", {31'd0, found}, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_en", bus.en_lcd, 0);
    chk("mid_rst_oe", bus.data_lcd_oe, 0);
    chk("mid_rst_rw", bus.rw_lcd, 1);
    chk("mid_rst_ready", bus.ready, 0);
    repeat (3) @(negedge clk);
    base = wcnt; dbase = done_cnt;
    rst = 1'b0;
    wait_ready(2000, "reinit_ready");
    repeat (2) @(negedge clk);
    build_init_exp();
    check_seq(base, "reinit");
    chk("reinit_no_done", done_cnt - dbase, 0);
    chk("reinit_err", bus.err, 0);

    chk("en_width", bad_width, 0);
    chk("write_oe", bad_oe, 0);
    chk("oe_rw_overlap", overlap, 0);
    chk("done_noready", done_noready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
